// File: rtl/uart_rx_controller.sv
// UART receiver: 2-FF synchroniser, oversampling deframer and 4-channel output demux.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_rx_controller #(
    parameter int unsigned CLK_FREQ   = 16000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] UART_config,
    input  logic       rx,
    output logic [7:0] rx_data_0,
    output logic [7:0] rx_data_1,
    output logic [7:0] rx_data_2,
    output logic [7:0] rx_data_3,
    output logic       rx_valid_0,
    output logic       rx_valid_1,
    output logic       rx_valid_2,
    output logic       rx_valid_3,
    output logic       rx_frame_err,
    output logic       rx_parity_err,
    output logic       rx_busy
);

    localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned S_W     = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned MID     = OVERSAMPLE / 2 - 1;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_e;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;
`endif

    logic [1:0]       sync_q;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [S_W-1:0]   s_q, s_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    state_e           state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [1:0]       ch_q, ch_d;
    logic             busy_q, busy_d;
    logic [3:0][7:0]  data_q, data_d;
    logic [3:0]       valid_q, valid_d;
    logic             ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic             par_bad_q, par_bad_d;
    logic             perr_q, perr_d;
`endif

    logic en, rx_s, tick, mid;
    logic unused_cfg;

    assign en         = UART_config[3];
    assign rx_s       = sync_q[1];
    assign tick       = en && (div_cnt_q == DIV_W'(DIV - 1));
    assign mid        = tick && (s_q == S_W'(MID));
    assign unused_cfg = ^{UART_config[7:6], UART_config[2:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= 2'b11;
            div_cnt_q <= '0;
            s_q       <= '0;
            bit_idx_q <= '0;
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            ch_q      <= '0;
            busy_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= '0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            sync_q    <= {sync_q[0], rx};
            div_cnt_q <= div_cnt_d;
            s_q       <= s_d;
            bit_idx_q <= bit_idx_d;
            state_q   <= state_d;
            shift_q   <= shift_d;
            ch_q      <= ch_d;
            busy_q    <= busy_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
`endif
        end
    end

    // Deframing FSM: the sample counter free-runs across bits so every sample lands mid-bit.
    always_comb begin
        div_cnt_d = div_cnt_q;
        s_d       = s_q;
        bit_idx_d = bit_idx_q;
        state_d   = state_q;
        shift_d   = shift_q;
        ch_d      = ch_q;
        busy_d    = busy_q;
        data_d    = data_q;
        valid_d   = '0;
        ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif
        if (!en) begin
            div_cnt_d = '0;
            s_d       = '0;
            bit_idx_d = '0;
            state_d   = ST_IDLE;
            busy_d    = 1'b0;
        end else begin
            div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
            if (tick) begin
                s_d = (s_q == S_W'(OVERSAMPLE - 1)) ? '0 : s_q + S_W'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    s_d       = '0;
                    bit_idx_d = '0;
                    if (tick && !rx_s) begin
                        state_d = ST_START;
                        ch_d    = UART_config[5:4];
                    end
                end
                ST_START: begin
                    if (mid) begin
                        if (!rx_s) begin
                            state_d   = ST_DATA;
                            busy_d    = 1'b1;
                            bit_idx_d = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (mid) begin
                        shift_d = {rx_s, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (mid) begin
                        par_bad_d = ^{shift_q, rx_s};
                        state_d   = ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (mid) begin
                        state_d   = ST_IDLE;
                        busy_d    = 1'b0;
                        bit_idx_d = '0;
                        if (!rx_s) begin
                            ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (par_bad_q) begin
                            perr_d = 1'b1;
`endif
                        end else begin
                            data_d[ch_q]  = shift_q;
                            valid_d[ch_q] = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign rx_data_0    = data_q[0];
    assign rx_data_1    = data_q[1];
    assign rx_data_2    = data_q[2];
    assign rx_data_3    = data_q[3];
    assign rx_valid_0   = valid_q[0];
    assign rx_valid_1   = valid_q[1];
    assign rx_valid_2   = valid_q[2];
    assign rx_valid_3   = valid_q[3];
    assign rx_frame_err = ferr_q;
    assign rx_busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign rx_parity_err = perr_q;
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_controller.sv
// Self-checking bench for uart_rx_controller: serial frames in, per-channel events checked
// against a frame-level expectation queue. Divider shrunk to 4 for short runs.
module tb_uart_rx_controller;

    localparam int unsigned CLK_FREQ = 614400;
    localparam int unsigned BAUD     = 9600;
    localparam int unsigned OS       = 16;
    localparam int          BITC     = int'((CLK_FREQ / (BAUD * OS)) * OS);

    typedef struct {
        logic [1:0] kind;   // 0 valid, 1 frame error, 2 parity error
        logic [1:0] ch;
        logic [7:0] data;
        longint     t;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] cfg = 8'h00;
    logic       rx  = 1'b1;
    logic [7:0] rx_data_0, rx_data_1, rx_data_2, rx_data_3;
    logic       rx_valid_0, rx_valid_1, rx_valid_2, rx_valid_3;
    logic       rx_frame_err, rx_parity_err, rx_busy;

    uart_rx_controller #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
        .clk(clk), .rst(rst), .UART_config(cfg), .rx(rx),
        .rx_data_0(rx_data_0), .rx_data_1(rx_data_1), .rx_data_2(rx_data_2), .rx_data_3(rx_data_3),
        .rx_valid_0(rx_valid_0), .rx_valid_1(rx_valid_1), .rx_valid_2(rx_valid_2), .rx_valid_3(rx_valid_3),
        .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    longint     cyc = 0;
    int         overlap_cnt = 0;
    int         busy_cnt = 0;
    ev_t        evq[$];
    ev_t        expq[$];
    logic [7:0] exp_data [4];
    logic [3:0] vld;
    logic [7:0] dat [4];

    assign vld    = {rx_valid_3, rx_valid_2, rx_valid_1, rx_valid_0};
    assign dat[0] = rx_data_0;
    assign dat[1] = rx_data_1;
    assign dat[2] = rx_data_2;
    assign dat[3] = rx_data_3;

    function automatic ev_t mk_ev(input logic [1:0] k, input logic [1:0] c, input logic [7:0] d, input longint t);
        ev_t e;
        e.kind = k; e.ch = c; e.data = d; e.t = t;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if ($countones({vld, rx_frame_err, rx_parity_err}) > 1) overlap_cnt <= overlap_cnt + 1;
        if (rx_busy) busy_cnt <= busy_cnt + 1;
        for (int c = 0; c < 4; c++)
            if (vld[c]) evq.push_back(mk_ev(2'd0, 2'(c), dat[c], cyc));
        if (rx_frame_err) evq.push_back(mk_ev(2'd1, 2'd0, 8'h00, cyc));
        if (rx_parity_err) evq.push_back(mk_ev(2'd2, 2'd0, 8'h00, cyc));
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        wait_clks(BITC);
    endtask

    // gs=0: stop bit held low just past its centre; gp=0: wrong parity bit (parity build).
    task automatic send_frame(input logic [7:0] b, input bit gs, input bit gp,
                              input int chg_bit, input logic [7:0] chg_cfg);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == chg_bit) cfg = chg_cfg;
            drive_bit(b[i]);
        end
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ !gp);
`endif
        if (gs) begin
            drive_bit(1'b1);
        end else begin
            rx = 1'b0;
            wait_clks(44);
            drive_bit(1'b1);
        end
    endtask

    // Frame-level reference: what one frame should produce, from the framing rules alone.
    task automatic model_frame(input logic [7:0] b, input logic [1:0] ch, input bit gs, input bit gp);
        bit par_ok;
`ifdef UART_RX_PARITY_EN
        par_ok = gp;
`else
        par_ok = 1'b1;
`endif
        if (!gs) expq.push_back(mk_ev(2'd1, 2'd0, 8'h00, 0));
        else if (!par_ok) expq.push_back(mk_ev(2'd2, 2'd0, 8'h00, 0));
        else begin
            expq.push_back(mk_ev(2'd0, ch, b, 0));
            exp_data[ch] = b;
        end
    endtask

    task automatic test_reset();
        wait_clks(3);
        checks++;
        if ({rx_data_3, rx_data_2, rx_data_1, rx_data_0} !== 32'h0) begin
            failures++; $display("FAIL reset_data actual=%h required=0", {rx_data_3, rx_data_2, rx_data_1, rx_data_0});
        end
        checks++;
        if ({vld, rx_frame_err, rx_parity_err, rx_busy} !== 7'b0) begin
            failures++; $display("FAIL reset_flags actual=%b required=0", {vld, rx_frame_err, rx_parity_err, rx_busy});
        end
        rst = 1'b0;
        wait_clks(BITC);
        checks++;
        if ({vld, rx_frame_err, rx_parity_err, rx_busy} !== 7'b0) begin
            failures++; $display("FAIL post_reset_flags actual=%b required=0", {vld, rx_frame_err, rx_parity_err, rx_busy});
        end
        for (int c = 0; c < 4; c++) exp_data[c] = 8'h00;
    endtask

    task automatic test_basic();
        int base;
        longint t0, lat;
        cfg = 8'h28;
        wait_clks(BITC);
        base = evq.size(); expq.delete();
        t0 = cyc;
        send_frame(8'hA5, 1'b1, 1'b1, -1, 8'h00);
        model_frame(8'hA5, 2'd2, 1'b1, 1'b1);
        wait_clks(2 * BITC);
        checks++;
        if (evq.size() - base != expq.size()) begin
            failures++; $display("FAIL basic_count actual=%0d required=%0d", evq.size() - base, expq.size());
        end
        for (int i = 0; i < expq.size() && base + i < evq.size(); i++) begin
            checks++;
            if ({evq[base+i].kind, evq[base+i].ch, evq[base+i].data} !== {expq[i].kind, expq[i].ch, expq[i].data}) begin
                failures++; $display("FAIL basic_event%0d actual=%h required=%h", i,
                    {evq[base+i].kind, evq[base+i].ch, evq[base+i].data}, {expq[i].kind, expq[i].ch, expq[i].data});
            end
        end
        if (evq.size() > base) begin
            lat = evq[base].t - t0;
            checks++;
            if (lat < longint'(17 * BITC / 2) || lat > longint'(21 * BITC / 2)) begin
                failures++; $display("FAIL basic_latency actual=%0d required=%0d+-%0d", lat, 19 * BITC / 2, BITC);
            end
        end
        checks++;
        if ({rx_data_3, rx_data_2, rx_data_1, rx_data_0} !== {exp_data[3], exp_data[2], exp_data[1], exp_data[0]}) begin
            failures++; $display("FAIL basic_data actual=%h required=%h", {rx_data_3, rx_data_2, rx_data_1, rx_data_0},
                {exp_data[3], exp_data[2], exp_data[1], exp_data[0]});
        end
    endtask

    task automatic test_glitch();
        int base, b0;
        base = evq.size(); b0 = busy_cnt;
        rx = 1'b0;
        wait_clks(3 * (BITC / int'(OS)));
        rx = 1'b1;
        wait_clks(2 * BITC);
        checks++;
        if (evq.size() != base) begin
            failures++; $display("FAIL glitch_events actual=%0d required=0", evq.size() - base);
        end
        checks++;
        if (busy_cnt - b0 > BITC || rx_busy !== 1'b0) begin
            failures++; $display("FAIL glitch_busy actual=%0d cycles now=%b required<=%0d now=0", busy_cnt - b0, rx_busy, BITC);
        end
    endtask

    task automatic test_frame_err();
        int base;
        logic [7:0] b;
        b = 8'($urandom);
        cfg = 8'h08;
        base = evq.size(); expq.delete();
        send_frame(b, 1'b1, 1'b1, -1, 8'h00);      model_frame(b, 2'd0, 1'b1, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b1, -1, 8'h00);  model_frame(8'h3C, 2'd0, 1'b0, 1'b1);
        wait_clks(2 * BITC);
        checks++;
        if (evq.size() - base != expq.size()) begin
            failures++; $display("FAIL ferr_count actual=%0d required=%0d", evq.size() - base, expq.size());
        end
        for (int i = 0; i < expq.size() && base + i < evq.size(); i++) begin
            checks++;
            if ({evq[base+i].kind, evq[base+i].ch, evq[base+i].data} !== {expq[i].kind, expq[i].ch, expq[i].data}) begin
                failures++; $display("FAIL ferr_event%0d actual=%h required=%h", i,
                    {evq[base+i].kind, evq[base+i].ch, evq[base+i].data}, {expq[i].kind, expq[i].ch, expq[i].data});
            end
        end
        checks++;
        if (rx_data_0 !== exp_data[0]) begin
            failures++; $display("FAIL ferr_data0 actual=%h required=%h", rx_data_0, exp_data[0]);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        cfg = 8'h18;
        base = evq.size(); expq.delete();
        send_frame(8'h00, 1'b1, 1'b1, -1, 8'h00);  model_frame(8'h00, 2'd1, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1, -1, 8'h00);  model_frame(8'hFF, 2'd1, 1'b1, 1'b1);
        wait_clks(2 * BITC);
        checks++;
        if (evq.size() - base != expq.size()) begin
            failures++; $display("FAIL b2b_count actual=%0d required=%0d", evq.size() - base, expq.size());
        end
        for (int i = 0; i < expq.size() && base + i < evq.size(); i++) begin
            checks++;
            if ({evq[base+i].kind, evq[base+i].ch, evq[base+i].data} !== {expq[i].kind, expq[i].ch, expq[i].data}) begin
                failures++; $display("FAIL b2b_event%0d actual=%h required=%h", i,
                    {evq[base+i].kind, evq[base+i].ch, evq[base+i].data}, {expq[i].kind, expq[i].ch, expq[i].data});
            end
        end
        checks++;
        if (rx_data_1 !== 8'hFF) begin
            failures++; $display("FAIL b2b_data1 actual=%h required=ff", rx_data_1);
        end
    endtask

    task automatic test_reset_midframe();
        int base;
        logic [7:0] b;
        b = 8'h55;
        cfg = 8'h38;
        base = evq.size(); expq.delete();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rx = b[4];
        wait_clks(BITC / 2);
        rst = 1'b1;
        wait_clks(3);
        rx = 1'b1;
        rst = 1'b0;
        wait_clks(2 * BITC);
        for (int c = 0; c < 4; c++) exp_data[c] = 8'h00;
        checks++;
        if (evq.size() != base || rx_busy !== 1'b0) begin
            failures++; $display("FAIL rst_mid_quiet actual=%0d events busy=%b required=0 events busy=0", evq.size() - base, rx_busy);
        end
        checks++;
        if ({rx_data_3, rx_data_2, rx_data_1, rx_data_0} !== 32'h0) begin
            failures++; $display("FAIL rst_mid_data actual=%h required=0", {rx_data_3, rx_data_2, rx_data_1, rx_data_0});
        end
        send_frame(8'h81, 1'b1, 1'b1, -1, 8'h00);  model_frame(8'h81, 2'd3, 1'b1, 1'b1);
        // Select changes mid-frame: the byte still goes to the select latched at the start bit.
        send_frame(8'h6E, 1'b1, 1'b1, 3, 8'h08);   model_frame(8'h6E, 2'd3, 1'b1, 1'b1);
        wait_clks(2 * BITC);
        checks++;
        if (evq.size() - base != expq.size()) begin
            failures++; $display("FAIL rst_mid_count actual=%0d required=%0d", evq.size() - base, expq.size());
        end
        for (int i = 0; i < expq.size() && base + i < evq.size(); i++) begin
            checks++;
            if ({evq[base+i].kind, evq[base+i].ch, evq[base+i].data} !== {expq[i].kind, expq[i].ch, expq[i].data}) begin
                failures++; $display("FAIL rst_mid_event%0d actual=%h required=%h", i,
                    {evq[base+i].kind, evq[base+i].ch, evq[base+i].data}, {expq[i].kind, expq[i].ch, expq[i].data});
            end
        end
    endtask

    task automatic test_disable();
        int base, b0;
        logic [7:0] b;
        b = 8'($urandom);
        cfg = 8'h10;
        base = evq.size(); b0 = busy_cnt; expq.delete();
        send_frame(b, 1'b1, 1'b1, -1, 8'h00);
        wait_clks(BITC);
        checks++;
        if (evq.size() != base || busy_cnt != b0) begin
            failures++; $display("FAIL dis_quiet actual=%0d events %0d busy required=0 0", evq.size() - base, busy_cnt - b0);
        end
        cfg = 8'h18;
        send_frame(b, 1'b1, 1'b1, 4, 8'h10);
        wait_clks(BITC);
        checks++;
        if (evq.size() != base || rx_busy !== 1'b0) begin
            failures++; $display("FAIL dis_mid actual=%0d events busy=%b required=0 events busy=0", evq.size() - base, rx_busy);
        end
        cfg = 8'h18;
        wait_clks(BITC);
        send_frame(~b, 1'b1, 1'b1, -1, 8'h00);  model_frame(~b, 2'd1, 1'b1, 1'b1);
        wait_clks(2 * BITC);
        checks++;
        if (evq.size() - base != 1 || (evq.size() > base &&
            {evq[base].kind, evq[base].ch, evq[base].data} !== {expq[0].kind, expq[0].ch, expq[0].data})) begin
            failures++; $display("FAIL dis_recover actual=%0d events required=1 event %h", evq.size() - base,
                {expq[0].kind, expq[0].ch, expq[0].data});
        end
        checks++;
        if ({rx_data_3, rx_data_2, rx_data_1, rx_data_0} !== {exp_data[3], exp_data[2], exp_data[1], exp_data[0]}) begin
            failures++; $display("FAIL dis_data actual=%h required=%h", {rx_data_3, rx_data_2, rx_data_1, rx_data_0},
                {exp_data[3], exp_data[2], exp_data[1], exp_data[0]});
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int base;
        cfg = 8'h08;
        base = evq.size(); expq.delete();
        send_frame(8'h07, 1'b1, 1'b1, -1, 8'h00);  model_frame(8'h07, 2'd0, 1'b1, 1'b1);
        send_frame(8'h07, 1'b1, 1'b0, -1, 8'h00);  model_frame(8'h07, 2'd0, 1'b1, 1'b0);
        send_frame(8'h18, 1'b0, 1'b0, -1, 8'h00);  model_frame(8'h18, 2'd0, 1'b0, 1'b0);
        wait_clks(2 * BITC);
        checks++;
        if (evq.size() - base != expq.size()) begin
            failures++; $display("FAIL par_count actual=%0d required=%0d", evq.size() - base, expq.size());
        end
        for (int i = 0; i < expq.size() && base + i < evq.size(); i++) begin
            checks++;
            if ({evq[base+i].kind, evq[base+i].ch, evq[base+i].data} !== {expq[i].kind, expq[i].ch, expq[i].data}) begin
                failures++; $display("FAIL par_event%0d actual=%h required=%h", i,
                    {evq[base+i].kind, evq[base+i].ch, evq[base+i].data}, {expq[i].kind, expq[i].ch, expq[i].data});
            end
        end
    endtask
`endif

    task automatic test_random();
        int base;
        logic [7:0] b;
        logic [1:0] ch;
        bit gs, gp;
        base = evq.size(); expq.delete();
        for (int k = 0; k < 12; k++) begin
            b  = 8'($urandom);
            ch = 2'($urandom_range(0, 3));
            gs = ($urandom_range(0, 4) != 0);
            gp = ($urandom_range(0, 4) != 0);
            cfg = {2'b00, ch, 4'b1000};
            send_frame(b, gs, gp, -1, 8'h00);
            model_frame(b, ch, gs, gp);
            rx = 1'b1;
            wait_clks($urandom_range(0, 2 * BITC));
        end
        wait_clks(2 * BITC);
        checks++;
        if (evq.size() - base != expq.size()) begin
            failures++; $display("FAIL rand_count actual=%0d required=%0d", evq.size() - base, expq.size());
        end
        for (int i = 0; i < expq.size() && base + i < evq.size(); i++) begin
            checks++;
            if ({evq[base+i].kind, evq[base+i].ch, evq[base+i].data} !== {expq[i].kind, expq[i].ch, expq[i].data}) begin
                failures++; $display("FAIL rand_event%0d actual=%h required=%h", i,
                    {evq[base+i].kind, evq[base+i].ch, evq[base+i].data}, {expq[i].kind, expq[i].ch, expq[i].data});
            end
        end
        checks++;
        if ({rx_data_3, rx_data_2, rx_data_1, rx_data_0} !== {exp_data[3], exp_data[2], exp_data[1], exp_data[0]}) begin
            failures++; $display("FAIL rand_data actual=%h required=%h", {rx_data_3, rx_data_2, rx_data_1, rx_data_0},
                {exp_data[3], exp_data[2], exp_data[1], exp_data[0]});
        end
    endtask

    task automatic test_no_overlap();
        checks++;
        if (overlap_cnt != 0) begin
            failures++; $display("FAIL pulse_overlap actual=%0d required=0", overlap_cnt);
        end
        checks++;
        if (rx_busy !== 1'b0) begin
            failures++; $display("FAIL final_busy actual=%b required=0", rx_busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_midframe();
        test_disable();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        test_no_overlap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
